// File: rtl/affine_alu_seq.sv
// Time-shares one external combinational ALU to compute x' = a11*x + a12*y + b1, y' = a21*x + a22*y + b2.
// Optional feature: define ALU_SEQ_SAT_EN to saturate overflowing adds instead of wrapping.

`ifndef RB
`define RB   2'b01
`define RADD 2'b10
`define RMUL 2'b11
`endif

module affine_alu_seq #(
    parameter int           N        = 8,
    parameter logic [N-1:0] A11_INIT = 8'h40,
    parameter logic [N-1:0] A12_INIT = 8'h00,
    parameter logic [N-1:0] A21_INIT = 8'h00,
    parameter logic [N-1:0] A22_INIT = 8'h40,
    parameter logic [N-1:0] B1_INIT  = 8'h00,
    parameter logic [N-1:0] B2_INIT  = 8'h00
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x_in,
    input  logic [N-1:0] y_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] x_out,
    output logic [N-1:0] y_out,
    output logic         ovf,
    input  logic         cfg_we,
    input  logic [2:0]   cfg_addr,
    input  logic [N-1:0] cfg_data,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [1:0]   alu_func,
    input  logic [N-1:0] alu_result
);

    typedef enum logic [3:0] {
        S_IDLE, S_M11, S_M12, S_A1, S_A1B, S_M21, S_M22, S_A2, S_A2B, S_DONE
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] x_q, x_d, y_q, y_d, p0_q, p0_d, p1_q, p1_d, s_q, s_d;
    logic [N-1:0] x_out_q, x_out_d, y_out_q, y_out_d;
    logic         ovf_q, ovf_d;
    logic [N-1:0] a11_q, a11_d, a12_q, a12_d, a21_q, a21_d, a22_q, a22_d;
    logic [N-1:0] b1_q, b1_d, b2_q, b2_d;
    logic         add_ovf;
    logic [N-1:0] add_val;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (in_valid) state_d = S_M11;
            S_M11:   state_d = S_M12;
            S_M12:   state_d = S_A1;
            S_A1:    state_d = S_A1B;
            S_A1B:   state_d = S_M21;
            S_M21:   state_d = S_M22;
            S_M22:   state_d = S_A2;
            S_A2:    state_d = S_A2B;
            S_A2B:   state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        alu_func  = `RB;
        alu_a     = '0;
        alu_b     = '0;
        unique case (state_q)
            S_M11:   begin alu_func = `RMUL; alu_a = a11_q; alu_b = x_q;  end
            S_M12:   begin alu_func = `RMUL; alu_a = a12_q; alu_b = y_q;  end
            S_A1:    begin alu_func = `RADD; alu_a = p0_q;  alu_b = p1_q; end
            S_A1B:   begin alu_func = `RADD; alu_a = s_q;   alu_b = b1_q; end
            S_M21:   begin alu_func = `RMUL; alu_a = a21_q; alu_b = x_q;  end
            S_M22:   begin alu_func = `RMUL; alu_a = a22_q; alu_b = y_q;  end
            S_A2:    begin alu_func = `RADD; alu_a = p0_q;  alu_b = p1_q; end
            S_A2B:   begin alu_func = `RADD; alu_a = s_q;   alu_b = b2_q; end
            default: begin alu_func = `RB;   alu_a = '0;    alu_b = '0;   end
        endcase
    end

    // Signed add overflow: like-signed operands producing an opposite-signed sum.
    always_comb begin
        add_ovf = (alu_func == `RADD) && (alu_a[N-1] == alu_b[N-1]) &&
                  (alu_result[N-1] != alu_a[N-1]);
`ifdef ALU_SEQ_SAT_EN
        if (add_ovf) begin
            add_val = alu_a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end else begin
            add_val = alu_result;
        end
`else
        add_val = alu_result;
`endif
    end

    always_comb begin
        x_d = x_q;  y_d = y_q;  p0_d = p0_q;  p1_d = p1_q;  s_d = s_q;
        x_out_d = x_out_q;  y_out_d = y_out_q;  ovf_d = ovf_q;
        a11_d = a11_q;  a12_d = a12_q;  a21_d = a21_q;  a22_d = a22_q;
        b1_d = b1_q;  b2_d = b2_q;
        unique case (state_q)
            S_IDLE: begin
                if (cfg_we) begin
                    case (cfg_addr)
                        3'd0:    a11_d = cfg_data;
                        3'd1:    a12_d = cfg_data;
                        3'd2:    a21_d = cfg_data;
                        3'd3:    a22_d = cfg_data;
                        3'd4:    b1_d  = cfg_data;
                        3'd5:    b2_d  = cfg_data;
                        default: ;
                    endcase
                end
                if (in_valid) begin
                    x_d   = x_in;
                    y_d   = y_in;
                    ovf_d = 1'b0;
                end
            end
            S_M11, S_M21: p0_d = alu_result;
            S_M12, S_M22: p1_d = alu_result;
            S_A1, S_A2:   begin s_d = add_val; ovf_d = ovf_q | add_ovf; end
            S_A1B:        begin x_out_d = add_val; ovf_d = ovf_q | add_ovf; end
            S_A2B:        begin y_out_d = add_val; ovf_d = ovf_q | add_ovf; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            x_q <= '0;  y_q <= '0;  p0_q <= '0;  p1_q <= '0;  s_q <= '0;
            x_out_q <= '0;  y_out_q <= '0;  ovf_q <= 1'b0;
            a11_q <= A11_INIT;  a12_q <= A12_INIT;  a21_q <= A21_INIT;  a22_q <= A22_INIT;
            b1_q <= B1_INIT;  b2_q <= B2_INIT;
        end else begin
            x_q <= x_d;  y_q <= y_d;  p0_q <= p0_d;  p1_q <= p1_d;  s_q <= s_d;
            x_out_q <= x_out_d;  y_out_q <= y_out_d;  ovf_q <= ovf_d;
            a11_q <= a11_d;  a12_q <= a12_d;  a21_q <= a21_d;  a22_q <= a22_d;
            b1_q <= b1_d;  b2_q <= b2_d;
        end
    end

    assign x_out = x_out_q;
    assign y_out = y_out_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_affine_alu_seq.sv
// Self-checking bench for affine_alu_seq: directed tables, corner sequences and a randomized reference model.

`ifndef RB
`define RB   2'b01
`define RADD 2'b10
`define RMUL 2'b11
`endif

module tb_affine_alu_seq;

   logic       clk = 1'b0;
   logic       n_reset = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] x_in = '0;
   logic [7:0] y_in = '0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] x_out, y_out;
   logic       ovf;
   logic       cfg_we = 1'b0;
   logic [2:0] cfg_addr = '0;
   logic [7:0] cfg_data = '0;
   logic [7:0] alu_a, alu_b, alu_result;
   logic [1:0] alu_func;
   logic signed [15:0] alu_prod;

   int assertCount = 0;
   int failCount = 0;
   int sinceAccept = 0;
   logic [1:0] funcSeq [0:8];
   int modelCoef [0:5];

   typedef struct {
      int x;
      int y;
      int ex;
      int ey;
      int eovf;
   } vec_t;
   vec_t vecs [0:5];

   affine_alu_seq dut (
      .clk(clk), .n_reset(n_reset),
      .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .y_in(y_in),
      .out_valid(out_valid), .out_ready(out_ready), .x_out(x_out), .y_out(y_out),
      .ovf(ovf), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_result(alu_result)
   );

   always #5 clk = ~clk;

   // Behavioural stand-in for the picoMIPS ALU: pass B, add, or Q1.7 multiply.
   assign alu_prod = $signed(alu_a) * $signed(alu_b);
   always_comb begin
      alu_result = alu_b;
      case (alu_func)
         `RADD:   alu_result = alu_a + alu_b;
         `RMUL:   alu_result = alu_prod[14:7];
         default: alu_result = alu_b;
      endcase
   end

   function automatic int wrap8(input int v);
      return ((v + 128) & 255) - 128;
   endfunction

   function automatic int mulQ(input int c, input int v);
      return wrap8((c * v) >>> 7);
   endfunction

   function automatic int addN(input int a, input int b, inout bit ov);
      int s;
      s = a + b;
      if (s > 127 || s < -128) begin
         ov = 1'b1;
`ifdef ALU_SEQ_SAT_EN
         s = (s > 127) ? 127 : -128;
`else
         s = wrap8(s);
`endif
      end
      return s;
   endfunction

   task automatic modelTransform(input int x, input int y, output int xo, output int yo, output bit ov);
      int s;
      ov = 1'b0;
      s  = addN(mulQ(modelCoef[0], x), mulQ(modelCoef[1], y), ov);
      xo = addN(s, modelCoef[4], ov);
      s  = addN(mulQ(modelCoef[2], x), mulQ(modelCoef[3], y), ov);
      yo = addN(s, modelCoef[5], ov);
   endtask

   task automatic modelReset();
      modelCoef[0] = 64;  modelCoef[1] = 0;  modelCoef[2] = 0;
      modelCoef[3] = 64;  modelCoef[4] = 0;  modelCoef[5] = 0;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      assertCount++;
      if (actual != expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   function automatic int sx(input logic [7:0] v);
      return int'($signed(v));
   endfunction

   task automatic doReset();
      in_valid = 1'b0;
      cfg_we = 1'b0;
      n_reset = 1'b0;
      repeat (2) @(negedge clk);
      n_reset = 1'b1;
      @(negedge clk);
      modelReset();
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      while (!in_ready && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) checkOutput("in_ready_timeout", 0, 1);
   endtask

   task automatic cfgWrite(input int addr, input int data);
      waitIdle();
      cfg_we = 1'b1;
      cfg_addr = addr[2:0];
      cfg_data = data[7:0];
      @(negedge clk);
      cfg_we = 1'b0;
      if (addr < 6) modelCoef[addr] = sx(data[7:0]);
   endtask

   task automatic applyStimulus(input int x, input int y);
      waitIdle();
      in_valid = 1'b1;
      x_in = x[7:0];
      y_in = y[7:0];
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      sinceAccept = 0;
      funcSeq[0] = alu_func;
   endtask

   task automatic stepOne();
      @(negedge clk);
      sinceAccept++;
      if (sinceAccept <= 8) funcSeq[sinceAccept] = alu_func;
   endtask

   task automatic waitDone();
      while (!out_valid && sinceAccept < 20) stepOne();
      checkOutput("latency", out_valid ? sinceAccept : -1, 8);
   endtask

   task automatic runAndCheck(input string tag, input int x, input int y);
      int ex, ey;
      bit eo;
      modelTransform(x, y, ex, ey, eo);
      applyStimulus(x, y);
      waitDone();
      checkOutput({tag, "_x"}, sx(x_out), ex);
      checkOutput({tag, "_y"}, sx(y_out), ey);
      checkOutput({tag, "_ovf"}, int'(ovf), int'(eo));
   endtask

   initial begin
      logic [1:0] expFunc [0:8];
      int hx, hy, hv;
      logic [7:0] rd;

      vecs[0] = '{100, -60, 60, -35, 0};
      vecs[1] = '{0, 0, 10, -5, 0};
      vecs[2] = '{-1, 1, 9, -5, 0};
      vecs[3] = '{127, -128, 73, -69, 0};
      vecs[4] = '{-128, 127, -54, 58, 0};
      vecs[5] = '{3, -3, 11, -7, 0};
      expFunc = '{`RMUL, `RMUL, `RADD, `RADD, `RMUL, `RMUL, `RADD, `RADD, `RB};

      doReset();
      checkOutput("rst_in_ready", int'(in_ready), 1);
      checkOutput("rst_out_valid", int'(out_valid), 0);
      checkOutput("rst_x_out", int'(x_out), 0);
      checkOutput("rst_y_out", int'(y_out), 0);
      checkOutput("rst_ovf", int'(ovf), 0);
      checkOutput("rst_alu_a", int'(alu_a), 0);
      checkOutput("rst_alu_b", int'(alu_b), 0);
      checkOutput("rst_alu_func", int'(alu_func), int'(`RB));

      // Table vectors with default multipliers, b1=10, b2=-5.
      cfgWrite(4, 10);
      cfgWrite(5, -5);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i].x, vecs[i].y);
         waitDone();
         checkOutput($sformatf("vec%0d_x", i), sx(x_out), vecs[i].ex);
         checkOutput($sformatf("vec%0d_y", i), sx(y_out), vecs[i].ey);
         checkOutput($sformatf("vec%0d_ovf", i), int'(ovf), vecs[i].eovf);
         if (i == 0) begin
            for (int k = 0; k < 9; k++)
               checkOutput($sformatf("op_order%0d", k), int'(funcSeq[k]), int'(expFunc[k]));
         end
      end

      // Overflow in the final x add.
      doReset();
      cfgWrite(1, 8'h40);
      cfgWrite(4, 10);
      applyStimulus(127, 127);
      waitDone();
`ifdef ALU_SEQ_SAT_EN
      checkOutput("ovf_x", sx(x_out), 127);
`else
      checkOutput("ovf_x", sx(x_out), -120);
`endif
      checkOutput("ovf_y", sx(y_out), 63);
      checkOutput("ovf_flag", int'(ovf), 1);
      runAndCheck("ovf_clear", 10, 10);

      // Backpressure in DONE, with a competing in_valid.
      doReset();
      out_ready = 1'b0;
      runAndCheck("bp_first", 20, 40);
      hx = int'(x_out);
      hy = int'(y_out);
      hv = int'(ovf);
      in_valid = 1'b1;
      x_in = 8'd5;
      y_in = 8'd6;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput($sformatf("bp_hold_x%0d", i), int'(x_out), hx);
         checkOutput($sformatf("bp_hold_y%0d", i), int'(y_out), hy);
         checkOutput($sformatf("bp_hold_ovf%0d", i), int'(ovf), hv);
         checkOutput($sformatf("bp_valid%0d", i), int'(out_valid), 1);
         checkOutput($sformatf("bp_in_ready%0d", i), int'(in_ready), 0);
         checkOutput($sformatf("bp_func%0d", i), int'(alu_func), int'(`RB));
      end
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput("bp_released_idle", int'(in_ready), 1);
      checkOutput("bp_released_valid", int'(out_valid), 0);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      sinceAccept = 0;
      waitDone();
      checkOutput("bp_second_x", sx(x_out), 2);
      checkOutput("bp_second_y", sx(y_out), 3);

      // Config writes outside IDLE are dropped.
      doReset();
      applyStimulus(64, 0);
      repeat (4) stepOne();
      cfg_we = 1'b1;
      cfg_addr = 3'd0;
      cfg_data = 8'h7F;
      stepOne();
      cfg_we = 1'b0;
      waitDone();
      checkOutput("cfg_busy_x0", sx(x_out), 32);
      applyStimulus(64, 0);
      waitDone();
      checkOutput("cfg_busy_x1", sx(x_out), 32);
      cfgWrite(0, 8'h7F);
      applyStimulus(64, 0);
      waitDone();
      checkOutput("cfg_idle_x", sx(x_out), 63);

      // Write coincident with accept is used by that transform.
      waitIdle();
      cfg_we = 1'b1;
      cfg_addr = 3'd4;
      cfg_data = 8'd7;
      applyStimulus(64, 0);
      cfg_we = 1'b0;
      waitDone();
      checkOutput("cfg_same_edge_x", sx(x_out), 70);

      // Reset asserted while in M22.
      doReset();
      cfgWrite(0, 8'h7F);
      cfgWrite(4, 10);
      cfgWrite(5, -5);
      applyStimulus(100, -60);
      repeat (5) stepOne();
      n_reset = 1'b0;
      #1;
      checkOutput("midrst_out_valid", int'(out_valid), 0);
      checkOutput("midrst_in_ready", int'(in_ready), 1);
      checkOutput("midrst_func", int'(alu_func), int'(`RB));
      checkOutput("midrst_x_out", int'(x_out), 0);
      @(negedge clk);
      n_reset = 1'b1;
      @(negedge clk);
      modelReset();
      applyStimulus(100, -60);
      waitDone();
      checkOutput("midrst_after_x", sx(x_out), 50);
      checkOutput("midrst_after_y", sx(y_out), -30);

      // Randomized coefficients and points against the reference model.
      doReset();
      for (int i = 0; i < 25; i++) begin
         for (int w = 0; w < 3; w++) begin
            rd = 8'($urandom);
            cfgWrite($urandom_range(0, 7), int'(rd));
         end
         rd = 8'($urandom);
         hx = sx(rd);
         rd = 8'($urandom);
         hy = sx(rd);
         runAndCheck($sformatf("rand%0d", i), hx, hy);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
